ctrl_unit: RTL and testbench

- Commit-side consumer of the MEM/WB pipeline register bundle (mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out).
- Owns the control registers and decides exceptions, exception return and control-register writes.
- Generates the per-stage stall/flush vector and new_pc that drive every pipeline register, including the EX/MEM register.

---
 rtl/ctrl_unit_pkg.sv | 39 +++
 rtl/ctrl_regfile.sv | 115 +++++++++++
 rtl/ctrl_unit.sv | 124 ++++++++++++
 tb/tb_ctrl_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_unit_pkg.sv
// rtl/ctrl_unit_pkg.sv - shared codes, control-register indices and field positions for ctrl_unit
package ctrl_unit_pkg;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        EXP_NO_EXP     = 3'd0,
        EXP_EXT_INT    = 3'd1,
        EXP_UNDEF      = 3'd2,
        EXP_OVFL       = 3'd3,
        EXP_MISS_ALIGN = 3'd4,
        EXP_TRAP       = 3'd5,
        EXP_PRV_VIO    = 3'd6
    } exp_code_e;

    localparam logic [4:0] CREG_STATUS     = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [4:0] CREG_EPC        = 5'd2;
    localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
    localparam logic [4:0] CREG_CAUSE      = 5'd4;
    localparam logic [4:0] CREG_INT_MASK   = 5'd5;
    localparam logic [4:0] CREG_IRQ        = 5'd6;

    localparam int STATUS_INT_EN_BIT   = 0;
    localparam int STATUS_EXE_MODE_BIT = 1;
    localparam int CAUSE_DLY_FLAG_BIT  = 3;

    localparam logic [7:0] INT_MASK_RST = 8'hFF;

    // A delay-slot instruction returns to its branch so the branch re-executes
    function automatic logic [29:0] epc_of(input logic [29:0] pc, input logic dly);
        return dly ? pc - 30'd1 : pc;
    endfunction

endpackage

// File: rtl/ctrl_regfile.sv
// rtl/ctrl_regfile.sv - control-register storage and read mux (IRQ sampling under CTRL_INT_EN)
module ctrl_regfile
    import ctrl_unit_pkg::*;
#(
    parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        exp_en,
    input  logic [3:0]  exp_cause,
    input  logic [29:0] exp_epc,
    input  logic        exrt_en,
    input  logic [7:0]  irq,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [1:0]  status,
    output logic [29:0] epc,
    output logic [29:0] exp_vector,
    output logic [7:0]  int_mask
);

    logic [1:0]  status_q, status_d;
    logic [1:0]  pre_status_q, pre_status_d;
    logic [29:0] epc_q, epc_d;
    logic [29:0] exp_vector_q, exp_vector_d;
    logic [3:0]  cause_q, cause_d;
    logic [7:0]  int_mask_q, int_mask_d;
    logic [7:0]  irq_q;
    logic        unused_bits;

    assign unused_bits = ^wr_data[31:30];

`ifdef CTRL_INT_EN
    // IRQ mirrors the raw request lines one cycle late
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 8'h00;
        else        irq_q <= irq;
    end
`else
    logic unused_irq;
    assign unused_irq = ^irq;
    assign irq_q      = 8'h00;
`endif

    // Next-state: exception beats return, return beats an ordinary register write
    always_comb begin
        status_d     = status_q;
        pre_status_d = pre_status_q;
        epc_d        = epc_q;
        exp_vector_d = exp_vector_q;
        cause_d      = cause_q;
        int_mask_d   = int_mask_q;
        if (exp_en) begin
            pre_status_d = status_q;
            status_d     = 2'b00;
            cause_d      = exp_cause;
            epc_d        = exp_epc;
        end else if (exrt_en) begin
            status_d = pre_status_q;
        end else if (wr_en) begin
            case (wr_addr)
                CREG_STATUS:     status_d     = wr_data[1:0];
                CREG_PRE_STATUS: pre_status_d = wr_data[1:0];
                CREG_EPC:        epc_d        = wr_data[29:0];
                CREG_EXP_VECTOR: exp_vector_d = wr_data[29:0];
                CREG_CAUSE:      cause_d      = wr_data[3:0];
                CREG_INT_MASK:   int_mask_d   = wr_data[7:0];
                default:         ;
            endcase
        end
    end

    // Register storage with asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q     <= 2'b00;
            pre_status_q <= 2'b00;
            epc_q        <= 30'h0;
            exp_vector_q <= EXP_VECTOR_RST;
            cause_q      <= 4'h0;
            int_mask_q   <= INT_MASK_RST;
        end else begin
            status_q     <= status_d;
            pre_status_q <= pre_status_d;
            epc_q        <= epc_d;
            exp_vector_q <= exp_vector_d;
            cause_q      <= cause_d;
            int_mask_q   <= int_mask_d;
        end
    end

    // Combinational read port; a same-cycle write is not forwarded
    always_comb begin
        rd_data = 32'h0;
        case (rd_addr)
            CREG_STATUS:     rd_data = {30'h0, status_q};
            CREG_PRE_STATUS: rd_data = {30'h0, pre_status_q};
            CREG_EPC:        rd_data = {2'b00, epc_q};
            CREG_EXP_VECTOR: rd_data = {2'b00, exp_vector_q};
            CREG_CAUSE:      rd_data = {28'h0, cause_q};
            CREG_INT_MASK:   rd_data = {24'h0, int_mask_q};
            CREG_IRQ:        rd_data = {24'h0, irq_q};
            default:         rd_data = 32'h0;
        endcase
    end

    assign status     = status_q;
    assign epc        = epc_q;
    assign exp_vector = exp_vector_q;
    assign int_mask   = int_mask_q;

endmodule

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - commit-side control unit: exceptions, EXRT, WRCR, stall/flush and redirect (CTRL_INT_EN adds interrupts)
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] mem_pc,
    input  logic        mem_en,
    input  logic        mem_br_flag,
    input  logic [1:0]  mem_ctrl_op,
    input  logic [4:0]  mem_dst_addr,
    input  logic        mem_gpr_we_,
    input  logic [2:0]  mem_exp_code,
    input  logic [31:0] mem_out,
    input  logic        if_busy,
    input  logic        ld_busy,
    input  logic [4:0]  creg_rd_addr,
    output logic [31:0] creg_rd_data,
    output logic        exe_mode,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic [29:0] new_pc,
    input  logic [7:0]  irq
);

    logic [1:0]  status;
    logic [29:0] epc;
    logic [29:0] exp_vector;
    logic [7:0]  int_mask;
    logic        stall_all;
    logic        commit;
    logic        take_exp;
    logic        take_exrt;
    logic        take_wrcr;
    logic        flush;
    logic [2:0]  exp_code;
    logic [3:0]  exp_cause;
    logic [29:0] exp_epc;
    logic        int_pend_q;
    logic        unused_ok;

    // GPR write enable belongs to the writeback path, not to this unit
    assign unused_ok = ^{mem_gpr_we_, int_mask, status[STATUS_INT_EN_BIT]};

`ifdef CTRL_INT_EN
    logic int_pend_d;

    // Pending interrupt: any unmasked request while interrupts are enabled
    always_comb begin
        int_pend_d = (|(irq & ~int_mask)) & status[STATUS_INT_EN_BIT];
    end

    // Registered so the interrupt decision never sits on the irq input path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) int_pend_q <= 1'b0;
        else        int_pend_q <= int_pend_d;
    end
`else
    assign int_pend_q = 1'b0;
`endif

    // Commit decision with priority exception > EXRT > WRCR
    always_comb begin
        stall_all = if_busy | ld_busy;
        commit    = !stall_all && mem_en;
        take_exp  = commit && ((mem_exp_code != EXP_NO_EXP) || int_pend_q);
        take_exrt = commit && !take_exp && (mem_ctrl_op == CTRL_OP_EXRT);
        take_wrcr = commit && !take_exp && !take_exrt && (mem_ctrl_op == CTRL_OP_WRCR);
        flush     = take_exp || take_exrt;
        // An interrupt rides on a clean bundle, so its own code is NO_EXP
        exp_code  = (mem_exp_code != EXP_NO_EXP) ? mem_exp_code : EXP_EXT_INT;
        exp_cause = 4'h0;
        exp_cause[CAUSE_DLY_FLAG_BIT] = mem_br_flag;
        exp_cause[2:0] = exp_code;
        exp_epc   = epc_of(mem_pc, mem_br_flag);
    end

    // Redirect target is only meaningful while flush is asserted
    always_comb begin
        new_pc = 30'h0;
        if (take_exp)       new_pc = exp_vector;
        else if (take_exrt) new_pc = epc;
    end

    assign if_stall  = stall_all;
    assign id_stall  = stall_all;
    assign ex_stall  = stall_all;
    assign mem_stall = stall_all;
    assign if_flush  = flush;
    assign id_flush  = flush;
    assign ex_flush  = flush;
    assign mem_flush = flush;
    assign exe_mode  = status[STATUS_EXE_MODE_BIT];

    ctrl_regfile #(
        .EXP_VECTOR_RST (EXP_VECTOR_RST)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (take_wrcr),
        .wr_addr    (mem_dst_addr),
        .wr_data    (mem_out),
        .exp_en     (take_exp),
        .exp_cause  (exp_cause),
        .exp_epc    (exp_epc),
        .exrt_en    (take_exrt),
        .irq        (irq),
        .rd_addr    (creg_rd_addr),
        .rd_data    (creg_rd_data),
        .status     (status),
        .epc        (epc),
        .exp_vector (exp_vector),
        .int_mask   (int_mask)
    );

endmodule

// File: tb/tb_ctrl_unit.sv
// tb/tb_ctrl_unit.sv - self-checking bench for ctrl_unit with directed and randomized commit traffic
module tb_ctrl_unit;

    localparam logic [29:0] VEC_RST = 30'h0000_1234;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic        if_busy, ld_busy;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc;
    logic [7:0]  irq;

    int checks = 0;
    int errors = 0;

    // reference state of the control registers
    logic [1:0]  m_status, m_pre;
    logic [29:0] m_epc, m_vec;
    logic [3:0]  m_cause;
    logic [7:0]  m_mask;

    ctrl_unit #(.EXP_VECTOR_RST(VEC_RST)) dut (
        .clk(clk), .reset(reset), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out),
        .if_busy(if_busy), .ld_busy(ld_busy), .creg_rd_addr(creg_rd_addr),
        .creg_rd_data(creg_rd_data), .exe_mode(exe_mode),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic br, input logic [1:0] op, input logic [4:0] dst,
                         input logic [2:0] code, input logic [31:0] dat, input logic [29:0] pc);
        mem_en = en; mem_br_flag = br; mem_ctrl_op = op; mem_dst_addr = dst;
        mem_exp_code = code; mem_out = dat; mem_pc = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        creg_rd_addr = a;
        #1;
        d = creg_rd_data;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd0:    return {30'h0, m_status};
            5'd1:    return {30'h0, m_pre};
            5'd2:    return {2'b00, m_epc};
            5'd3:    return {2'b00, m_vec};
            5'd4:    return {28'h0, m_cause};
            5'd5:    return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(); if_busy = 0; ld_busy = 0; irq = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        m_status = 0; m_pre = 0; m_epc = 0; m_vec = VEC_RST; m_cause = 0; m_mask = 8'hFF;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; idle(); if_busy = 0; ld_busy = 0; irq = 8'h00; mem_gpr_we_ = 1'b1;
        creg_rd_addr = 0;
        repeat (2) @(negedge clk);
        rd(5'd3, d); checks++; if (d !== {2'b00, VEC_RST}) begin errors++; $display("FAIL reset_exp_vector got %h want %h", d, {2'b00, VEC_RST}); end
        rd(5'd5, d); checks++; if (d !== 32'hFF) begin errors++; $display("FAIL reset_int_mask got %h want 000000ff", d); end
        rd(5'd0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        checks++; if ({if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush} !== 8'h00 || new_pc !== 30'h0) begin
            errors++; $display("FAIL reset_outputs got stall/flush %b new_pc %h want 0", {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush}, new_pc); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_wrcr();
        logic [31:0] d;
        @(negedge clk); drive(1, 0, 2'd1, 5'd0, 3'd0, 32'hFFFF_FFFF, 30'h10);
        #1; checks++; if ({if_flush, id_flush, ex_flush, mem_flush} !== 4'h0) begin errors++; $display("FAIL wrcr_no_flush got %b want 0000", {if_flush, id_flush, ex_flush, mem_flush}); end
        rd(5'd0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrcr_no_bypass got %h want 0", d); end
        @(negedge clk); drive(1, 0, 2'd1, 5'd3, 3'd0, 32'h100, 30'h11);
        rd(5'd3, d); checks++; if (d !== {2'b00, VEC_RST}) begin errors++; $display("FAIL wrcr_vec_old got %h want %h", d, {2'b00, VEC_RST}); end
        @(negedge clk); idle();
        rd(5'd3, d); checks++; if (d !== 32'h100) begin errors++; $display("FAIL wrcr_vec got %h want 00000100", d); end
        rd(5'd0, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL wrcr_status_masked got %h want 3", d); end
        checks++; if (exe_mode !== 1'b1) begin errors++; $display("FAIL wrcr_exe_mode got %b want 1", exe_mode); end
        @(negedge clk); drive(1, 0, 2'd1, 5'd7, 3'd0, 32'hFFFF_FFFF, 30'h12);
        @(negedge clk); drive(1, 0, 2'd1, 5'd6, 3'd0, 32'hFFFF_FFFF, 30'h13);
        @(negedge clk); idle();
        rd(5'd7, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
        rd(5'd6, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_readonly got %h want 0", d); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        @(negedge clk); drive(1, 1, 2'd0, 5'd0, 3'd4, 32'h0, 30'h40);
        #1; checks++; if ({if_flush, id_flush, ex_flush, mem_flush} !== 4'hF || new_pc !== 30'h100) begin
            errors++; $display("FAIL exp_flush got %b/%h want 1111/100", {if_flush, id_flush, ex_flush, mem_flush}, new_pc); end
        @(negedge clk); idle();
        rd(5'd2, d); checks++; if (d !== 32'h3F) begin errors++; $display("FAIL exp_epc got %h want 3f", d); end
        rd(5'd4, d); checks++; if (d !== 32'hC) begin errors++; $display("FAIL exp_cause got %h want c", d); end
        rd(5'd1, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL exp_pre_status got %h want 3", d); end
        rd(5'd0, d); checks++; if (d !== 32'h0 || exe_mode !== 1'b0) begin errors++; $display("FAIL exp_status got %h/%b want 0/0", d, exe_mode); end
    endtask

    task automatic test_exrt();
        logic [31:0] d;
        @(negedge clk); drive(1, 0, 2'd2, 5'd0, 3'd0, 32'h0, 30'h77);
        #1; checks++; if ({if_flush, id_flush, ex_flush, mem_flush} !== 4'hF || new_pc !== 30'h3F) begin
            errors++; $display("FAIL exrt_flush got %b/%h want 1111/3f", {if_flush, id_flush, ex_flush, mem_flush}, new_pc); end
        @(negedge clk); idle();
        rd(5'd0, d); checks++; if (d !== 32'h3 || exe_mode !== 1'b1) begin errors++; $display("FAIL exrt_status got %h/%b want 3/1", d, exe_mode); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ld_busy = (i != 1); if_busy = (i == 1);
            drive(1, 0, 2'd0, 5'd0, 3'd3, 32'h0, 30'h55);
            #1; checks++; if ({if_stall, id_stall, ex_stall, mem_stall} !== 4'hF || {if_flush, id_flush, ex_flush, mem_flush} !== 4'h0) begin
                errors++; $display("FAIL stall_hold got stall %b flush %b want 1111/0000", {if_stall, id_stall, ex_stall, mem_stall}, {if_flush, id_flush, ex_flush, mem_flush}); end
            rd(5'd2, d); checks++; if (d !== 32'h3F) begin errors++; $display("FAIL stall_no_update got %h want 3f", d); end
        end
        @(negedge clk); ld_busy = 0; if_busy = 0;
        #1; checks++; if ({if_stall, if_flush, mem_flush} !== 3'b011 || new_pc !== 30'h100) begin
            errors++; $display("FAIL stall_release got stall/flush %b new_pc %h want 011/100", {if_stall, if_flush, mem_flush}, new_pc); end
        @(negedge clk); drive(0, 0, 2'd1, 5'd3, 3'd5, 32'hABC, 30'h66);
        #1; checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL disabled_bundle_flush got %b want 0", if_flush); end
        rd(5'd2, d); checks++; if (d !== 32'h55) begin errors++; $display("FAIL stall_epc got %h want 55", d); end
        rd(5'd4, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL stall_cause got %h want 3", d); end
        @(negedge clk); idle();
        rd(5'd3, d); checks++; if (d !== 32'h100) begin errors++; $display("FAIL disabled_bundle_write got %h want 100", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        @(negedge clk); drive(1, 0, 2'd0, 5'd0, 3'd2, 32'h0, 30'h99);
        #1; reset = 1'b0;
        rd(5'd2, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_epc got %h want 0", d); end
        rd(5'd3, d); checks++; if (d !== {2'b00, VEC_RST}) begin errors++; $display("FAIL midreset_vec got %h want %h", d, {2'b00, VEC_RST}); end
        @(posedge clk); #1;
        rd(5'd4, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_cause got %h want 0", d); end
        @(negedge clk); idle(); reset = 1'b1;
    endtask

    task automatic test_random();
        logic        e_stall, e_commit, e_exp, e_exrt, e_wr;
        logic [29:0] e_pc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if_busy = ($urandom_range(0, 9) == 0);
            ld_busy = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 4) != 0, 1'($urandom), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 6)),
                  $urandom, 30'($urandom));
            creg_rd_addr = 5'($urandom_range(0, 7));
            #1;
            e_stall  = if_busy | ld_busy;
            e_commit = !e_stall && mem_en;
            e_exp    = e_commit && (mem_exp_code != 0);
            e_exrt   = e_commit && !e_exp && (mem_ctrl_op == 2'd2);
            e_wr     = e_commit && !e_exp && !e_exrt && (mem_ctrl_op == 2'd1);
            e_pc     = e_exp ? m_vec : m_epc;
            checks++; if ({if_stall, id_stall, ex_stall, mem_stall} !== {4{e_stall}}) begin errors++; $display("FAIL rand_stall got %b want %b", {if_stall, id_stall, ex_stall, mem_stall}, {4{e_stall}}); end
            checks++; if ({if_flush, id_flush, ex_flush, mem_flush} !== {4{e_exp | e_exrt}}) begin errors++; $display("FAIL rand_flush got %b want %b", {if_flush, id_flush, ex_flush, mem_flush}, {4{e_exp | e_exrt}}); end
            if (e_exp | e_exrt) begin
                checks++; if (new_pc !== e_pc) begin errors++; $display("FAIL rand_new_pc got %h want %h", new_pc, e_pc); end
            end
            checks++; if (creg_rd_data !== model_read(creg_rd_addr)) begin errors++; $display("FAIL rand_read[%0d] got %h want %h", creg_rd_addr, creg_rd_data, model_read(creg_rd_addr)); end
            checks++; if (exe_mode !== m_status[1]) begin errors++; $display("FAIL rand_exe_mode got %b want %b", exe_mode, m_status[1]); end
            if (e_exp) begin
                m_pre = m_status; m_status = 2'b00; m_cause = {mem_br_flag, mem_exp_code};
                m_epc = mem_br_flag ? mem_pc - 30'd1 : mem_pc;
            end else if (e_exrt) begin
                m_status = m_pre;
            end else if (e_wr) begin
                case (mem_dst_addr)
                    5'd0: m_status = mem_out[1:0];
                    5'd1: m_pre    = mem_out[1:0];
                    5'd2: m_epc    = mem_out[29:0];
                    5'd3: m_vec    = mem_out[29:0];
                    5'd4: m_cause  = mem_out[3:0];
                    5'd5: m_mask   = mem_out[7:0];
                    default: ;
                endcase
            end
        end
        @(negedge clk); idle(); if_busy = 0; ld_busy = 0;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        do_reset();
        @(negedge clk); drive(1, 0, 2'd1, 5'd0, 3'd0, 32'h1, 30'h1);
        @(negedge clk); drive(1, 0, 2'd1, 5'd5, 3'd0, 32'hFE, 30'h2);
        @(negedge clk); drive(1, 0, 2'd1, 5'd3, 3'd0, 32'h200, 30'h3);
`ifdef CTRL_INT_EN
        @(negedge clk); idle(); irq = 8'h02;
        repeat (2) @(negedge clk);
        drive(1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h30);
        #1; checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL int_masked got flush %b want 0", if_flush); end
        @(negedge clk); idle(); irq = 8'h01;
        repeat (2) @(negedge clk);
        rd(5'd6, d); checks++; if (d !== 32'h01) begin errors++; $display("FAIL int_irq_reg got %h want 1", d); end
        drive(1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h20);
        #1; checks++; if ({if_flush, mem_flush} !== 2'b11 || new_pc !== 30'h200) begin errors++; $display("FAIL int_take got %b/%h want 11/200", {if_flush, mem_flush}, new_pc); end
        @(negedge clk); idle(); irq = 8'h00;
        rd(5'd4, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL int_cause got %h want 1", d); end
        rd(5'd2, d); checks++; if (d !== 32'h20) begin errors++; $display("FAIL int_epc got %h want 20", d); end
        rd(5'd0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL int_status got %h want 0", d); end
`else
        @(negedge clk); idle(); irq = 8'hFF;
        repeat (2) @(negedge clk);
        rd(5'd6, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_reg_off got %h want 0", d); end
        drive(1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h20);
        #1; checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL irq_off_flush got %b want 0", if_flush); end
        @(negedge clk); idle(); irq = 8'h00;
`endif
    endtask

    initial begin
        test_reset();
        test_wrcr();
        test_exception();
        test_exrt();
        test_stall();
        test_reset_mid();
        test_random();
        test_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
